// File: rtl/ibex_counter_bank.sv
// Memory-mapped bank of 32-bit event counters with enable (CTRL) and sticky
// overflow (OVF) registers, answering every request one cycle later.
module ibex_counter_bank #(
  parameter int unsigned NumCounters = 8,
  parameter logic [31:0] BaseAddr    = 32'h0002_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   counter_req_i,
  input  logic                   counter_we_i,
  input  logic [31:0]            counter_addr_i,
  input  logic [31:0]            counter_wdata_i,
  output logic                   counter_rvalid_o,
  output logic [31:0]            counter_rdata_o,
  output logic                   counter_err_o,
  input  logic [NumCounters-1:0] event_i
);

  // Handshake: a request is accepted in every cycle counter_req_i is high (no
  // ready signal, no stall); exactly one response follows in the next cycle,
  // flagged by a single-cycle counter_rvalid_o, in request order.

  localparam logic [31:0] BankEnd = BaseAddr + 32'(16 + 4 * NumCounters);

  logic [31:0]            r_cnt [NumCounters];
  logic [NumCounters-1:0] r_ctrl;
  logic [NumCounters-1:0] r_ovf;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic                   r_err;

  logic                   w_err;
  logic                   w_acc;
  logic                   w_wr;
  logic [9:0]             w_word;
  logic                   w_ctrl_sel;
  logic                   w_ovf_sel;
  logic [NumCounters-1:0] w_cnt_wr;
  logic [NumCounters-1:0] w_inc;
  logic [NumCounters-1:0] w_wrap;
  logic [NumCounters-1:0] w_ovf_clr;
  logic [31:0]            w_ctrl_ext;
  logic [31:0]            w_ovf_ext;
  logic [31:0]            w_rd_data;

  // BaseAddr is 4 KiB aligned, so the word offset is just the low address bits.
  assign w_word     = counter_addr_i[11:2];
  assign w_err      = (counter_addr_i[1:0] != 2'b00) ||
                      (counter_addr_i < BaseAddr) ||
                      (counter_addr_i >= BankEnd);
  assign w_acc      = counter_req_i & ~w_err;
  assign w_wr       = w_acc & counter_we_i;
  assign w_ctrl_sel = (w_word == 10'd0);
  assign w_ovf_sel  = (w_word == 10'd1);

  always_comb begin
    w_ctrl_ext = '0;
    w_ovf_ext  = '0;
    w_ctrl_ext[NumCounters-1:0] = r_ctrl;
    w_ovf_ext[NumCounters-1:0]  = r_ovf;
  end

  always_comb begin
    w_cnt_wr  = '0;
    w_rd_data = '0;
    if (w_ctrl_sel) begin
      w_rd_data = w_ctrl_ext;
    end else if (w_ovf_sel) begin
      w_rd_data = w_ovf_ext;
    end
    for (int i = 0; i < int'(NumCounters); i++) begin
      if (w_word == 10'(i + 4)) begin
        w_cnt_wr[i] = w_wr;
        w_rd_data   = r_cnt[i];
      end
    end
  end

  // A write to a counter overrides that cycle's increment and its overflow.
  assign w_inc     = r_ctrl & event_i;
  always_comb begin
    w_wrap = '0;
    for (int i = 0; i < int'(NumCounters); i++) begin
      w_wrap[i] = w_inc[i] & ~w_cnt_wr[i] & (r_cnt[i] == 32'hFFFF_FFFF);
    end
  end
  assign w_ovf_clr = (w_wr && w_ovf_sel) ? counter_wdata_i[NumCounters-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumCounters); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NumCounters); i++) begin
        if (w_cnt_wr[i]) begin
          r_cnt[i] <= counter_wdata_i;
        end else if (w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Set beats clear when a W1C lands on the same edge as a new wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl <= '0;
      r_ovf  <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;
      if (w_wr && w_ctrl_sel) begin
        r_ctrl <= counter_wdata_i[NumCounters-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= counter_req_i;
      r_err    <= counter_req_i & w_err;
      r_rdata  <= (w_acc && !counter_we_i) ? w_rd_data : 32'd0;
    end
  end

  assign counter_rvalid_o = r_rvalid;
  assign counter_rdata_o  = r_rdata;
  assign counter_err_o    = r_err;

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Bench for ibex_counter_bank: directed scenarios plus randomized traffic
// checked against an arithmetic model of the register bank.
module tb_ibex_counter_bank;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h0002_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [N-1:0]  ev = '0;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0]   m_cnt [N];
  logic [N-1:0]  m_ctrl;
  logic [N-1:0]  m_ovf;

  // Observed and predicted response of the last step
  logic          o_v, o_e, x_v, x_e;
  logic [31:0]   o_d, x_d;

  ibex_counter_bank #(.NumCounters(N), .BaseAddr(BASE)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .counter_req_i   (req),
    .counter_we_i    (we),
    .counter_addr_i  (addr),
    .counter_wdata_i (wdata),
    .counter_rvalid_o(rvalid),
    .counter_rdata_o (rdata),
    .counter_err_o   (err),
    .event_i         (ev)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    m_ctrl = '0;
    m_ovf  = '0;
  endtask

  // One clock: drive at a falling edge, sample the response at the next one,
  // and advance the model by the same request and events.
  task automatic step(input logic s_req, input logic s_we, input logic [31:0] s_addr,
                      input logic [31:0] s_wdata, input logic [N-1:0] s_ev);
    longint       off;
    bit           bad;
    int           word;
    logic [N-1:0] set_bits;
    logic [N-1:0] clr_bits;
    longint       nxt;
    off  = longint'(s_addr) - longint'(BASE);
    bad  = (s_addr % 4 != 0) || off < 0 || off >= 16 + 4 * N;
    word = int'(off / 4);
    x_v  = s_req;
    x_e  = s_req && bad;
    x_d  = 32'd0;
    if (s_req && !bad && !s_we) begin
      if (word == 0)      x_d = 32'(m_ctrl);
      else if (word == 1) x_d = 32'(m_ovf);
      else if (word >= 4) x_d = m_cnt[word - 4];
    end
    req = s_req; we = s_we; addr = s_addr; wdata = s_wdata; ev = s_ev;
    @(negedge clk);
    o_v = rvalid; o_e = err; o_d = rdata;
    req = 1'b0;
    ev  = '0;
    set_bits = '0;
    clr_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (s_req && !bad && s_we && word == i + 4) begin
        m_cnt[i] = s_wdata;
      end else if (m_ctrl[i] && s_ev[i]) begin
        nxt = longint'(m_cnt[i]) + 1;
        if (nxt == 64'h1_0000_0000) begin
          m_cnt[i]    = 32'd0;
          set_bits[i] = 1'b1;
        end else begin
          m_cnt[i] = 32'(nxt);
        end
      end
    end
    if (s_req && !bad && s_we && word == 1) clr_bits = s_wdata[N-1:0];
    m_ovf = (m_ovf & ~clr_bits) | set_bits;
    if (s_req && !bad && s_we && word == 0) m_ctrl = s_wdata[N-1:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rvalid, err, rdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b e=%b d=%h, want all 0", rvalid, err, rdata);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, BASE, 32'd0, '0);
      n_checks++;
      if ({o_v, o_e, o_d} !== 34'd0) begin
        n_fail++; $display("FAIL idle_no_rvalid: got v=%b e=%b d=%h, want all 0", o_v, o_e, o_d);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, BASE + ((k == 2) ? 32'h10 : 32'(4 * k)), 32'd0, '0);
      n_checks++;
      if ({o_v, o_e, o_d} !== {1'b1, 1'b0, 32'd0}) begin
        n_fail++; $display("FAIL reset_read%0d: got v=%b e=%b d=%h, want v=1 e=0 d=0", k, o_v, o_e, o_d);
      end
    end
  endtask

  task automatic test_counting();
    logic [31:0] exp_cnt [4];
    exp_cnt = '{32'd10, 32'd0, 32'd10, 32'd0};
    step(1'b1, 1'b1, BASE, 32'h0000_0005, '0);
    repeat (10) step(1'b0, 1'b0, BASE, 32'd0, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, BASE + 32'h10 + 32'(4 * k), 32'd0, '0);
      n_checks++;
      if ({o_v, o_e, o_d} !== {1'b1, 1'b0, exp_cnt[k]}) begin
        n_fail++; $display("FAIL count_cnt%0d: got v=%b e=%b d=%h, want d=%h", k, o_v, o_e, o_d, exp_cnt[k]);
      end
    end
    step(1'b1, 1'b0, BASE, 32'd0, '0);
    n_checks++;
    if (o_d !== 32'h5) begin
      n_fail++; $display("FAIL count_ctrl: got %h want 00000005", o_d);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b1, BASE + 32'h18, 32'hFFFF_FFFE, '0);
    repeat (3) step(1'b0, 1'b0, BASE, 32'd0, 8'h04);
    step(1'b1, 1'b0, BASE + 32'h18, 32'd0, '0);
    n_checks++;
    if (o_d !== 32'h1) begin
      n_fail++; $display("FAIL ovf_cnt2: got %h want 00000001", o_d);
    end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0, '0);
    n_checks++;
    if (o_d !== 32'h4) begin
      n_fail++; $display("FAIL ovf_set: got %h want 00000004", o_d);
    end
    step(1'b1, 1'b1, BASE + 32'h4, 32'h4, '0);
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0, '0);
    n_checks++;
    if (o_d !== 32'h0) begin
      n_fail++; $display("FAIL ovf_w1c: got %h want 00000000", o_d);
    end
  endtask

  task automatic test_write_collision();
    step(1'b1, 1'b1, BASE, 32'h0000_0007, '0);
    step(1'b1, 1'b1, BASE + 32'h14, 32'h0000_1234, 8'h02);
    step(1'b1, 1'b0, BASE + 32'h14, 32'd0, '0);
    n_checks++;
    if (o_d !== 32'h1234) begin
      n_fail++; $display("FAIL collide_cnt1: got %h want 00001234", o_d);
    end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0, '0);
    n_checks++;
    if (o_d[1] !== 1'b0) begin
      n_fail++; $display("FAIL collide_ovf1: got %b want 0", o_d[1]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] bad_addr [3];
    logic        bad_we   [3];
    bad_addr = '{BASE + 32'h2, BASE + 32'h10 + 32'(4 * N), BASE - 32'h4};
    bad_we   = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, bad_we[k], bad_addr[k], 32'hDEAD_BEEF, '0);
      n_checks++;
      if ({o_v, o_e, o_d} !== {1'b1, 1'b1, 32'd0}) begin
        n_fail++; $display("FAIL err%0d: got v=%b e=%b d=%h, want v=1 e=1 d=0", k, o_v, o_e, o_d);
      end
    end
    step(1'b1, 1'b0, BASE, 32'd0, '0);
    n_checks++;
    if (o_d !== 32'h7) begin
      n_fail++; $display("FAIL err_no_change: ctrl got %h want 00000007", o_d);
    end
  endtask

  task automatic test_random();
    logic        r_req, r_we;
    logic [31:0] r_addr, r_wdata;
    int          sel;
    for (int k = 0; k < 400; k++) begin
      r_req = ($urandom_range(0, 3) != 0);
      r_we  = ($urandom_range(0, 2) == 0);
      sel   = int'($urandom_range(0, 15));
      if (sel < 12)       r_addr = BASE + 32'(4 * $urandom_range(0, N + 3));
      else if (sel == 12) r_addr = BASE + 32'($urandom_range(1, 3));
      else if (sel == 13) r_addr = BASE + 32'h10 + 32'(4 * N);
      else if (sel == 14) r_addr = BASE - 32'h4;
      else                r_addr = BASE + 32'(4 * $urandom_range(0, 20)) + 32'($urandom_range(0, 3));
      r_wdata = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      step(r_req, r_we, r_addr, r_wdata, N'($urandom));
      n_checks++;
      if ({o_v, o_e, o_d} !== {x_v, x_e, x_d}) begin
        n_fail++;
        $display("FAIL random[%0d] addr=%h we=%b: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                 k, r_addr, r_we, o_v, o_e, o_d, x_v, x_e, x_d);
      end
    end
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b0, BASE + 32'h10 + 32'(4 * i), 32'd0, '0);
      n_checks++;
      if (o_d !== x_d) begin
        n_fail++; $display("FAIL random_final_cnt%0d: got %h want %h", i, o_d, x_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals = '{32'hA5A5_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int k = 0; k < 6; k++) begin
      step(1'b1, (k % 2 == 0), BASE + 32'h1C, vals[k / 2], '0);
      n_checks++;
      if (o_v !== 1'b1 || o_e !== 1'b0) begin
        n_fail++; $display("FAIL b2b_rvalid%0d: got v=%b e=%b want v=1 e=0", k, o_v, o_e);
      end
      if (k % 2 == 1) begin
        n_checks++;
        if (o_d !== vals[k / 2]) begin
          n_fail++; $display("FAIL b2b_read%0d: got %h want %h", k, o_d, vals[k / 2]);
        end
      end
    end
    req = 1'b1; we = 1'b0; addr = BASE + 32'h1C;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL b2b_reset_drop: got v=%b d=%h want v=0 d=0", rvalid, rdata);
    end
    req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, BASE, 32'd0, '0);
    n_checks++;
    if (o_v !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got v=%b want 0", o_v);
    end
    for (int w = 0; w < N + 2; w++) begin
      step(1'b1, 1'b0, BASE + ((w < 2) ? 32'(4 * w) : 32'h10 + 32'(4 * (w - 2))), 32'd0, '0);
      n_checks++;
      if ({o_v, o_e, o_d} !== {1'b1, 1'b0, 32'd0}) begin
        n_fail++; $display("FAIL post_reset_reg%0d: got v=%b e=%b d=%h want v=1 e=0 d=0", w, o_v, o_e, o_d);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_counting();
    test_overflow();
    test_write_collision();
    test_errors();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
